alu4_exec: RTL
==============

ALU4_EXEC -- requirements
Module: alu4_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 SHL a by 1, 111 MUL.
REQ-007 SHALL have ports: a, b  input  WIDTH  operands.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: result, result_hi  output  WIDTH  low/high result word; result_hi is the MUL upper half, 0 for all other ops.
REQ-011 SHALL have ports: flag_c, flag_z, flag_v, flag_n  output  1  carry, zero, signed overflow, negative.

Function
REQ-012 SHALL use FSM states IDLE, BUSY, DONE; in_ready = 1 in IDLE, or in DONE when out_ready = 1; otherwise 0.
REQ-013 SHALL accept a request only on a cycle with in_valid && in_ready, capturing op, a and b.
REQ-014 SHALL transfer a result only on a cycle with out_valid && out_ready; out_valid = 1 exactly in DONE.
REQ-015 Non-MUL op accepted: SHALL go to DONE next cycle, so latency is 1 cycle.
REQ-016 MUL accepted: SHALL go to BUSY and run WIDTH shift-add iterations, one per cycle, then go to DONE; latency is WIDTH+1 cycles (5 at WIDTH=4).
REQ-017 In DONE, if out_ready = 1 and in_valid = 1 on the same cycle, SHALL retire the result and accept the new request (back-to-back, no bubble).
REQ-018 In DONE, if out_ready = 1 and in_valid = 0, SHALL return to IDLE.
REQ-019 In DONE with out_ready = 0, SHALL hold result, result_hi and flags stable.
REQ-020 In BUSY, SHALL ignore in_valid (in_ready = 0) and not depend on out_ready.
REQ-021 ADD: {flag_c, result} = a + b; flag_v = operand signs equal and result sign differs.
REQ-022 SUB: result = a - b mod 2^WIDTH; flag_c = 1 when a < b unsigned (borrow); flag_v = operand signs differ and result sign differs from a.
REQ-023 AND/OR/XOR/NOT: bitwise results; flag_c = 0, flag_v = 0.
REQ-024 SHL: result = {a[WIDTH-2:0], 0}; flag_c = a[WIDTH-1]; flag_v = 0.
REQ-025 MUL: {result_hi, result} = a * b unsigned; flag_c = (result_hi != 0); flag_v = 0.
REQ-026 flag_z SHALL be 1 iff result == 0 and result_hi == 0; flag_n SHALL equal result[WIDTH-1].
REQ-027 All outputs SHALL be registered (no combinational input-to-output path except in_ready from out_ready).

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, result/result_hi 0, all flags 0; in_ready then follows REQ-012.
REQ-029 Reset asserted during BUSY or DONE SHALL abandon the operation; no result is later produced for it.
REQ-030 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with in_valid = 1.

Structure
REQ-031 Opcode encodings and state encodings SHALL be localparams in a shared definitions file (alu4_defs), used by the block and the bench.
REQ-032 Single-cycle ops SHALL be computed in one combinational sub-module alu4_logic (inputs op, a, b; outputs result, c, v); the FSM and multiplier stay in alu4_exec.

Verification
REQ-033 ADD a=7 b=9, out_ready=1 -> one cycle later out_valid=1, result=0, flag_c=1, flag_z=1, flag_v=0.
REQ-034 SUB a=8 b=1 -> result=7, flag_v=1, flag_c=0, flag_n=0; SUB a=1 b=2 -> result=15, flag_c=1, flag_n=1.
REQ-035 MUL a=15 b=15 -> in_ready=0 for 4 cycles, out_valid on cycle 5, result=1, result_hi=14, flag_c=1.
REQ-036 XOR a=5 b=3 with out_ready=0 for 3 cycles -> result=6 held stable, in_ready=0; then out_ready=1 with ADD 2+2 pending -> both transfers happen on the same edge, and result=4 follows next cycle.
REQ-037 rst_n pulsed low mid-MUL (BUSY, iteration 2) -> out_valid=0 and all outputs 0 immediately; no stale result after release.
REQ-038 Random 1000-op stream with random in_valid/out_ready -> every result and flag matches reference model, in order, none lost or duplicated.

Source files
------------

// File: rtl/alu4_defs.sv
// Shared definitions for the alu4 execution block and its bench.
// Holds opcode encodings, FSM state encodings and the flag bundle type.
package alu4_defs;

  localparam int unsigned OP_W = 3;

  // Opcode encodings
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_MUL = 3'b111;

  // FSM state encodings
  localparam int unsigned    ST_W    = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  typedef enum logic [ST_W-1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  // Condition flags travelling with each result
  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } flags_t;

  // Only the multiply takes the iterative path through BUSY
  function automatic logic is_multi_cycle(logic [OP_W-1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu4_logic.sv
// Combinational datapath for all single-cycle opcodes.
// Ports:
//   op     - opcode (MUL yields zero here; it is handled by the caller)
//   a, b   - operands
//   result - low result word
//   c      - carry / borrow / shifted-out bit
//   v      - signed overflow
module alu4_logic
  import alu4_defs::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  localparam int unsigned SW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] diff;

  // Extra bit on the adder captures the unsigned carry-out
  assign sum  = SW'(a) + SW'(b);
  assign diff = a - b;

  // Opcode decode with flag generation
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff;
        c      = (a < b);
        v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        c      = a[MSB];
      end
      default: begin
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu4_exec.sv
// 4-bit ALU execution unit with valid/ready handshakes on both sides.
// Single-cycle ops complete one cycle after acceptance; MUL runs a
// WIDTH-iteration shift-add sequence in BUSY before reaching DONE.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid / in_ready   - request handshake (in_ready combinational from out_ready)
//   op, a, b              - request opcode and operands
//   out_valid / out_ready - result handshake
//   result, result_hi     - low / high result words (high only non-zero for MUL)
//   flag_c/z/v/n          - carry, zero, signed overflow, negative
module alu4_exec
  import alu4_defs::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [PW-1:0]    acc_sum;
  logic [WIDTH-1:0] lg_result;
  logic             lg_c;
  logic             lg_v;

  // Single-cycle datapath works straight off the request inputs
  alu4_logic #(
    .WIDTH (WIDTH)
  ) u_logic (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (lg_result),
    .c      (lg_c),
    .v      (lg_v)
  );

  // A finished result draining this cycle frees the slot for a new request
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (is_multi_cycle(op)) begin
            state_d     = BUSY;
            out_valid_d = 1'b0;
            acc_d       = '0;
            mcand_d     = PW'(a);
            mplier_d    = b;
            cnt_d       = '0;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = lg_result;
            result_hi_d = '0;
            flags_d.c   = lg_c;
            flags_d.z   = (lg_result == '0);
            flags_d.v   = lg_v;
            flags_d.n   = lg_result[WIDTH-1];
          end
        end
      end

      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration publishes the product directly from the adder
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = acc_sum[WIDTH-1:0];
          result_hi_d = acc_sum[PW-1:WIDTH];
          flags_d.c   = |acc_sum[PW-1:WIDTH];
          flags_d.z   = (acc_sum == '0);
          flags_d.v   = 1'b0;
          flags_d.n   = acc_sum[WIDTH-1];
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_v    = flags_q.v;
  assign flag_n    = flags_q.n;

endmodule
